// File: rtl/sha256_pkg.sv
// SHA-256 constants, shared types and bit-level helper functions for the nonce hash engine.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  state_e;

  localparam state_e S_IDLE  = 3'd0;
  localparam state_e S_RUN2  = 3'd1;
  localparam state_e S_FIN2  = 3'd2;
  localparam state_e S_LOAD3 = 3'd3;
  localparam state_e S_RUN3  = 3'd4;
  localparam state_e S_FIN3  = 3'd5;
  localparam state_e S_DONE  = 3'd6;

  // Padding for the second hash: a single 256-bit message in one block
  localparam word_t PAD_WORD = 32'h80000000;
  localparam word_t LEN_WORD = 32'h00000100;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; index 0 of the state vector is a, index 7 is h.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t [7:0] state_i,
  input  word_t       w_i,
  input  word_t       k_i,
  output word_t [7:0] state_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = state_i[7] + bsig1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
    t2 = bsig0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);
    state_o[0] = t1 + t2;
    state_o[1] = state_i[0];
    state_o[2] = state_i[1];
    state_o[3] = state_i[2];
    state_o[4] = state_i[3] + t1;
    state_o[5] = state_i[4];
    state_o[6] = state_i[5];
    state_o[7] = state_i[6];
  end

endmodule

// File: rtl/nonce_hash_engine.sv
// Per-nonce SHA256d engine: midstate + block-2 compression, then a second hash of that digest.
// Define FULL_DIGEST_EN to expose the whole final digest on digest_out.
module nonce_hash_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0][31:0] input_message,
  input  logic [31:0]       input_hash0,
  input  logic [31:0]       input_hash1,
  input  logic [31:0]       input_hash2,
  input  logic [31:0]       input_hash3,
  input  logic [31:0]       input_hash4,
  input  logic [31:0]       input_hash5,
  input  logic [31:0]       input_hash6,
  input  logic [31:0]       input_hash7,
  output logic              done,
  output logic [31:0]       output_mod
`ifdef FULL_DIGEST_EN
  ,
  output logic [255:0]      digest_out
`endif
);

  state_e      state_q, state_d;
  logic [6:0]  t_q, t_d;
  word_t [15:0] w_q, w_d;
  word_t [7:0] work_q, work_d;
  word_t [7:0] hash_q, hash_d;
  word_t       out_q, out_d;
  word_t [7:0] hashIn;
  word_t [7:0] roundNext;
  word_t       wNew;
  logic        lastRound;
`ifdef FULL_DIGEST_EN
  logic [255:0] digest_q, digest_d;
`endif

  assign hashIn = {input_hash7, input_hash6, input_hash5, input_hash4,
                   input_hash3, input_hash2, input_hash1, input_hash0};
  assign wNew      = w_q[0] + ssig0(w_q[1]) + w_q[9] + ssig1(w_q[14]);
  assign lastRound = (t_q == 7'(ROUNDS - 1));

  sha256_round u_round (
    .state_i (work_q),
    .w_i     (w_q[0]),
    .k_i     (K[t_q[5:0]]),
    .state_o (roundNext)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    work_d  = work_q;
    hash_d  = hash_q;
    out_d   = out_q;
`ifdef FULL_DIGEST_EN
    digest_d = digest_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = input_message;
          hash_d  = hashIn;
          work_d  = hashIn;
          t_d     = '0;
          state_d = S_RUN2;
        end
      end
      S_RUN2, S_RUN3: begin
        work_d = roundNext;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = wNew;
        t_d     = t_q + 7'd1;
        if (lastRound) state_d = (state_q == S_RUN2) ? S_FIN2 : S_FIN3;
      end
      S_FIN2: begin
        for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + work_q[i];
        state_d = S_LOAD3;
      end
      // The phase-2 digest becomes a single padded block hashed from the IV
      S_LOAD3: begin
        for (int i = 0; i < 8; i++) begin
          w_d[i]    = hash_q[i];
          hash_d[i] = IV[i];
          work_d[i] = IV[i];
        end
        w_d[8] = PAD_WORD;
        for (int i = 9; i < 15; i++) w_d[i] = '0;
        w_d[15] = LEN_WORD;
        t_d     = '0;
        state_d = S_RUN3;
      end
      S_FIN3: begin
        out_d = hash_q[0] + work_q[0];
`ifdef FULL_DIGEST_EN
        for (int i = 0; i < 8; i++) digest_d[255 - 32*i -: 32] = hash_q[i] + work_q[i];
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      w_q     <= '0;
      work_q  <= '0;
      hash_q  <= '0;
      out_q   <= '0;
`ifdef FULL_DIGEST_EN
      digest_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_q     <= w_d;
      work_q  <= work_d;
      hash_q  <= hash_d;
      out_q   <= out_d;
`ifdef FULL_DIGEST_EN
      digest_q <= digest_d;
`endif
    end
  end

  assign done       = (state_q == S_DONE);
  assign output_mod = out_q;
`ifdef FULL_DIGEST_EN
  assign digest_out = digest_q;
`endif

endmodule

// File: tb/tb_nonce_hash_engine.sv
// Directed bench for nonce_hash_engine: known SHA256d vectors, handshake, input capture and reset abort.
// Expected digests come from constants or an independent full-schedule SHA-256 model.
module tb_nonce_hash_engine;
  import sha256_pkg::*;

  localparam int LATENCY = 132;
  localparam int BUDGET  = 400;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0][31:0] msgIn = '0;
  logic [7:0][31:0]  hashIn = '0;
  logic              done;
  logic [31:0]       outputMod;
`ifdef FULL_DIGEST_EN
  logic [255:0]      digestOut;
`endif

  int checks = 0;
  int errors = 0;

  nonce_hash_engine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .input_message (msgIn),
    .input_hash0   (hashIn[0]),
    .input_hash1   (hashIn[1]),
    .input_hash2   (hashIn[2]),
    .input_hash3   (hashIn[3]),
    .input_hash4   (hashIn[4]),
    .input_hash5   (hashIn[5]),
    .input_hash6   (hashIn[6]),
    .input_hash7   (hashIn[7]),
    .done          (done),
    .output_mod    (outputMod)
`ifdef FULL_DIGEST_EN
    ,
    .digest_out    (digestOut)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] h, input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  function automatic logic [7:0][31:0] ivWords();
    logic [7:0][31:0] v;
    for (int i = 0; i < 8; i++) v[i] = IV[i];
    return v;
  endfunction

  function automatic logic [31:0] modelH0(input logic [7:0][31:0] mid, input logic [15:0][31:0] msg);
    logic [7:0][31:0]  d;
    logic [15:0][31:0] m2;
    d  = compress(mid, msg);
    m2 = '0;
    for (int i = 0; i < 8; i++) m2[i] = d[i];
    m2[8]  = 32'h80000000;
    m2[15] = 32'h00000100;
    d = compress(ivWords(), m2);
    return d[0];
  endfunction

  function automatic logic [15:0][31:0] makeBlock(input logic [31:0] nonce);
    logic [15:0][31:0] m;
    m = '0;
    m[0]  = 32'h4b1e5e4a;
    m[1]  = 32'h29ab5f49;
    m[2]  = 32'hffff001d;
    m[3]  = nonce;
    m[4]  = 32'h80000000;
    m[15] = 32'h00000280;
    return m;
  endfunction

  function automatic logic [15:0][31:0] abcBlock();
    logic [15:0][31:0] m;
    m = '0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    return m;
  endfunction

  function automatic logic [7:0][31:0] midA();
    logic [7:0][31:0] v;
    v[0] = 32'hbc909a33; v[1] = 32'h6358bff0; v[2] = 32'h90ccac7d; v[3] = 32'h1e59caa8;
    v[4] = 32'hc3c8d8e9; v[5] = 32'h4f0103c8; v[6] = 32'h96b18736; v[7] = 32'h4719f91b;
    return v;
  endfunction

  function automatic logic [7:0][31:0] midB();
    logic [7:0][31:0] v;
    v[0] = 32'h01234567; v[1] = 32'h89abcdef; v[2] = 32'hfedcba98; v[3] = 32'h76543210;
    v[4] = 32'h0f1e2d3c; v[5] = 32'h4b5a6978; v[6] = 32'h8796a5b4; v[7] = 32'hc3d2e1f0;
    return v;
  endfunction

  // Drops start for one edge, then requests a run; cycles counts edges with the accept edge as 1
  task automatic applyStimulus(input logic [15:0][31:0] msg, input logic [7:0][31:0] mid,
                               input bit scramble, output int cycles);
    start = 1'b0;
    @(posedge clk); #1;
    msgIn  = msg;
    hashIn = mid;
    start  = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    while (done !== 1'b1 && cycles < BUDGET) begin
      if (scramble) begin
        for (int i = 0; i < 16; i++) msgIn[i] = $urandom;
        for (int i = 0; i < 8; i++) hashIn[i] = $urandom;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++;
    if (outputMod !== 32'h0) begin errors++; $display("[TB] FAIL reset_output got %h want 00000000", outputMod); end
    reset_n = 1'b1;
  endtask

  task automatic test_abc();
    int cyc;
    applyStimulus(abcBlock(), ivWords(), 1'b0, cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("[TB] FAIL abc_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (outputMod !== 32'h4f8b42c2) begin errors++; $display("[TB] FAIL abc_h0 got %h want 4f8b42c2", outputMod); end
`ifdef FULL_DIGEST_EN
    checks++;
    if (digestOut !== 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358) begin
      errors++;
      $display("[TB] FAIL abc_digest got %h", digestOut);
    end
`endif
  endtask

  task automatic test_handshake();
    int drops;
    int cyc;
    logic [31:0] exp;
    drops = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || outputMod !== 32'h4f8b42c2) drops++;
    end
    checks++;
    if (drops != 0) begin errors++; $display("[TB] FAIL hold_done bad cycles got %0d want 0", drops); end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL release_done got %b want 0", done); end
    checks++;
    if (outputMod !== 32'h4f8b42c2) begin errors++; $display("[TB] FAIL release_hold got %h want 4f8b42c2", outputMod); end
    exp = modelH0(midA(), makeBlock(32'h00000042));
    applyStimulus(makeBlock(32'h00000042), midA(), 1'b0, cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("[TB] FAIL rerun_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (outputMod !== exp) begin errors++; $display("[TB] FAIL rerun_h0 got %h want %h", outputMod, exp); end
  endtask

  task automatic test_input_stability();
    int cyc;
    logic [31:0] exp;
    exp = modelH0(midB(), makeBlock(32'h1234abcd));
    applyStimulus(makeBlock(32'h1234abcd), midB(), 1'b1, cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("[TB] FAIL stable_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (outputMod !== exp) begin errors++; $display("[TB] FAIL stable_h0 got %h want %h", outputMod, exp); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic [31:0] exp;
    exp = modelH0(midA(), makeBlock(32'h00000007));
    start = 1'b0;
    @(posedge clk); #1;
    msgIn  = makeBlock(32'h00000007);
    hashIn = midA();
    start  = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", done); end
    checks++;
    if (outputMod !== 32'h0) begin errors++; $display("[TB] FAIL abort_output got %h want 00000000", outputMod); end
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(makeBlock(32'h00000007), midA(), 1'b0, cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("[TB] FAIL abort_rerun_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (outputMod !== exp) begin errors++; $display("[TB] FAIL abort_rerun_h0 got %h want %h", outputMod, exp); end
  endtask

  task automatic test_lanes();
    int cyc;
    logic [31:0] exp;
    for (int n = 0; n < 16; n++) begin
      exp = modelH0(midB(), makeBlock(32'(n)));
      applyStimulus(makeBlock(32'(n)), midB(), 1'b0, cyc);
      checks++;
      if (outputMod !== exp || cyc != LATENCY) begin
        errors++;
        $display("[TB] FAIL lane%0d got %h after %0d want %h after %0d", n, outputMod, cyc, exp, LATENCY);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] exp;
    exp = modelH0(midA(), makeBlock(32'hdeadbeef));
    applyStimulus(makeBlock(32'hdeadbeef), midA(), 1'b0, cyc);
    checks++;
    if (outputMod !== exp) begin errors++; $display("[TB] FAIL b2b_first got %h want %h", outputMod, exp); end
    applyStimulus(abcBlock(), ivWords(), 1'b0, cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("[TB] FAIL b2b_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (outputMod !== 32'h4f8b42c2) begin errors++; $display("[TB] FAIL b2b_second got %h want 4f8b42c2", outputMod); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_handshake();
    test_input_stability();
    test_reset_mid_run();
    test_lanes();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nonce_hash_engine.md
Name: nonce_hash_engine

Overview:
- Per-nonce SHA-256 engine for the bitcoin hasher. One instance per nonce lane, 16 lanes in parallel.
- Consumes the block-1 midstate (8x32) and one prepared 16-word block-2 message.
- Phase 2: one compression of the message seeded with the midstate.
- Phase 3: one compression of the padded 256-bit phase-2 digest seeded with the SHA-256 IV. Returns word H0 of the final digest to the top-level writer.

Parameters:
- ROUNDS, 64, compression rounds per phase (fixed by SHA-256; exposed only for the bench's short-run checks).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level request; sampled only in IDLE
- input_message  input  16x32  block-2 words W0..W15, W0 first; sampled on the start-accept edge
- input_hash0..input_hash7  input  32 each  phase-2 initial hash (midstate); sampled on the start-accept edge
- done  output  1  high while result is valid
- output_mod  output  32  final digest word H0

Behaviour:
- Reset (async, reset_n low): state=IDLE; done=0; output_mod=0; round counter=0. Reset mid-run aborts immediately; no partial result survives.
- State machine: IDLE -> LOAD2 -> RUN2 -> FIN2 -> LOAD3 -> RUN3 -> FIN3 -> DONE.
- IDLE: on start=1, capture input_message into 16-word schedule window w[0..15]; capture input_hash0..7 into H and into a..h; go RUN2.
  - LOAD2 is merged into this accept cycle.
- RUN2/RUN3, one round per cycle, t=0..63:
  - {a..h} <= round(a..h, w[0], K[t]).
  - Window shifts: w[i] <= w[i+1]; w[15] <= w[0] + s0(w[1]) + w[9] + s1(w[14]).
  - Exit after t=63.
  - All arithmetic is mod 2^32. Rotates and shifts use the standard SHA-256 sigma/Sigma amounts.
- FIN2: D[i] = H[i] + {a..h}[i].
- LOAD3:
  - w[0..7] = D0..D7; w[8] = 0x80000000; w[9..14] = 0; w[15] = 0x00000100.
  - H and a..h <= IV (0x6a09e667, 0xbb67ae85, 0x3c6ef372, 0xa54ff53a, 0x510e527f, 0x9b05688c, 0x1f83d9ab, 0x5be0cd19).
- FIN3: output_mod <= H0 + a; go DONE.
- DONE: done=1, output_mod held stable.
  - Stay while start=1.
  - On start=0: go IDLE and drop done. output_mod keeps its value until the next FIN3.
- Latency: accept edge -> done rising = 1 + 64 + 1 + 1 + 64 + 1 = 132 clocks. Fixed; no data-dependent variation.
- Inputs are ignored outside the accept edge. Upstream may change them during a run with no effect.
- start held high through DONE does not retrigger. A new run needs start to go low, then high again in IDLE.
- t counter is 7 bits. It is cleared at every RUN entry and never wraps past 64.

Optional Feature:
- FULL_DIGEST_EN defined:
  - Adds output port digest_out (256 bits) = final H0..H7, MSW = H0.
  - Loaded in FIN3, held like output_mod; 0 after reset.
- Undefined: port absent; H1..H7 final adds not synthesised. output_mod behaviour identical either way.

Decomposition:
- Package sha256_pkg:
  - K[64] constant table and IV[8] constants.
  - typedef word_t (logic [31:0]); typedef state_e.
  - Functions rotr, bsig0, bsig1, ssig0, ssig1, ch, maj.
  - Phase-3 pad constants: 0x80000000 and length 0x100.
- One sub-module: sha256_round (combinational). Takes a..h, w, k; returns the next a..h. Reused by both phases.
- Schedule window and FSM stay in nonce_hash_engine.

Test Plan:
- "abc" vector: midstate=IV; W0=0x61626380, W1..W14=0, W15=0x00000018; start=1 -> done rises exactly 132 clocks after accept, output_mod=0x4f8b42c2 (SHA256d("abc")). With FULL_DIGEST_EN, digest_out=4f8b42c2...3e6c6358.
- Handshake: keep start=1 for 20 cycles after done -> done stays 1, no rerun. Drop start -> done=0 next edge. Reassert -> new 132-cycle run.
- Input stability: randomise input_message and input_hash0..7 every cycle during the run -> result equals the value captured at accept.
- Reset mid-RUN3 (cycle ~100): done=0 and output_mod=0 asynchronously. Rerun after release gives correct result.
- 16 lanes, real header block 2 with nonces 0..15 -> each output_mod matches the software SHA256d H0 model.
- Back-to-back: two runs with different midstates, start low for 1 cycle between -> both results correct; no stale schedule words leak.
